// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
//   Shared definitions for the Gray-count receive path.
//   - GRAY_MAX_W : widest Gray/binary word the helper functions handle.
//   - rx_state_t : lock-state encoding driven on gray_rx_decode.lock_state.
//   - gray2bin / bin2gray : width-agnostic conversions. Callers zero-extend
//     their word to GRAY_MAX_W and truncate the result back to their width.
//     The zero upper bits decode to zero, so the result is correct for any
//     width up to GRAY_MAX_W.
// ---------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } rx_state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = {GRAY_MAX_W{1'b0}};
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: XOR each bit with its upper neighbour.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ {1'b0, b[GRAY_MAX_W-1:1]};
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// ---------------------------------------------------------------------------
// gray_sync_chain
//   STAGES-deep, WIDTH-wide flop chain that brings an asynchronous Gray word
//   into the clk domain. Only one bit of a Gray word changes per count, so a
//   plain per-bit synchroniser never produces a torn multi-bit value.
// Ports
//   clk  in   1      clock
//   rst  in   1      asynchronous active-high reset, clears every stage
//   d    in   WIDTH  asynchronous input word
//   q    out  WIDTH  synchronised word (last stage)
// ---------------------------------------------------------------------------
module gray_sync_chain
    import gray_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_r [STAGES];

    // Shift the incoming word one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/gray_rx_decode.sv
// ---------------------------------------------------------------------------
// gray_rx_decode
//   Receives a free-running Gray count from another clock domain,
//   synchronises and decodes it, checks each sampled step for a legal
//   forward distance, and tracks lock state.
// Ports
//   clk         in   1       clock
//   rst         in   1       asynchronous active-high reset
//   gray_in     in   CBITS   Gray count from the upstream counter (async)
//   bin_out     out  CBITS   decoded binary count, registered
//   bin_valid   out  1       bin_out is trusted (state TRACK)
//   wrap_pulse  out  1       one-cycle pulse on a legal step through zero
//   step_err    out  1       one-cycle pulse on an illegal step
//   err_cnt     out  ERR_W   saturating count of step_err pulses
//   lock_state  out  2       current rx_state_t
//   wrap_cnt    out  16      wraps since reset (GRAY_RX_WRAP_CNT_EN only)
// Build option
//   GRAY_RX_WRAP_CNT_EN : adds the wrap_cnt port and its modulo-2^16 counter.
// ---------------------------------------------------------------------------
module gray_rx_decode
    import gray_pkg::*;
#(
    parameter int CBITS       = 18,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 4,
    parameter int LOCK_GOOD   = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_valid,
    output logic             wrap_pulse,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output rx_state_t        lock_state
`ifdef GRAY_RX_WRAP_CNT_EN
    ,
    output logic [15:0]      wrap_cnt
`endif
);

    localparam int ACQ_W  = $clog2(SYNC_STAGES + 1);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam logic [CBITS-1:0]  MAX_STEP_C  = CBITS'(MAX_STEP);
    localparam logic [ACQ_W-1:0]  ACQ_LAST_C  = ACQ_W'(SYNC_STAGES);
    localparam logic [GOOD_W-1:0] LOCK_GOOD_C = GOOD_W'(LOCK_GOOD);

    logic [CBITS-1:0]  gray_sync_s;
    logic [CBITS-1:0]  bin_new_s;
    logic [CBITS-1:0]  delta_s;
    logic              legal_s;
    logic              moved_s;

    rx_state_t         state_r, state_nxt_s;
    logic [ACQ_W-1:0]  acq_cnt_r, acq_cnt_nxt_s;
    logic [GOOD_W-1:0] good_cnt_r, good_cnt_nxt_s;
    logic [CBITS-1:0]  bin_ref_r, bin_ref_nxt_s;
    logic              step_err_nxt_s;
    logic              wrap_nxt_s;

    logic [CBITS-1:0]  bin_out_r;
    logic              bin_valid_r;
    logic              wrap_pulse_r;
    logic              step_err_r;
    logic [ERR_W-1:0]  err_cnt_r;

    gray_sync_chain #(
        .WIDTH  (CBITS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (gray_sync_s)
    );

    assign bin_new_s = CBITS'(gray2bin(GRAY_MAX_W'(gray_sync_s)));
    // Modulo subtraction makes a forward step through zero look small.
    assign delta_s   = bin_new_s - bin_ref_r;
    assign legal_s   = (delta_s <= MAX_STEP_C);
    assign moved_s   = (delta_s != {CBITS{1'b0}});

    // Lock FSM next state, step classification and counter updates.
    always_comb begin
        state_nxt_s    = state_r;
        acq_cnt_nxt_s  = acq_cnt_r;
        good_cnt_nxt_s = good_cnt_r;
        bin_ref_nxt_s  = bin_ref_r;
        step_err_nxt_s = 1'b0;
        wrap_nxt_s     = 1'b0;
        case (state_r)
            ACQUIRE: begin
                // Wait until reset zeros have drained out of the sync chain.
                if (acq_cnt_r == ACQ_LAST_C) begin
                    bin_ref_nxt_s = bin_new_s;
                    acq_cnt_nxt_s = {ACQ_W{1'b0}};
                    state_nxt_s   = TRACK;
                end else begin
                    acq_cnt_nxt_s = acq_cnt_r + ACQ_W'(1);
                end
            end
            TRACK: begin
                bin_ref_nxt_s = bin_new_s;
                if (!legal_s) begin
                    step_err_nxt_s = 1'b1;
                    good_cnt_nxt_s = {GOOD_W{1'b0}};
                    state_nxt_s    = FAULT;
                end else begin
                    wrap_nxt_s = moved_s && (bin_new_s < bin_ref_r);
                end
            end
            FAULT: begin
                bin_ref_nxt_s = bin_new_s;
                // An illegal step always restarts the good-step run, even
                // on the edge that would otherwise re-enter TRACK.
                if (!legal_s) begin
                    step_err_nxt_s = 1'b1;
                    good_cnt_nxt_s = {GOOD_W{1'b0}};
                end else if (good_cnt_r == LOCK_GOOD_C) begin
                    good_cnt_nxt_s = {GOOD_W{1'b0}};
                    state_nxt_s    = TRACK;
                end else if (moved_s) begin
                    good_cnt_nxt_s = good_cnt_r + GOOD_W'(1);
                end else begin
                    good_cnt_nxt_s = good_cnt_r;
                end
            end
            default: begin
                acq_cnt_nxt_s  = {ACQ_W{1'b0}};
                good_cnt_nxt_s = {GOOD_W{1'b0}};
                state_nxt_s    = ACQUIRE;
            end
        endcase
    end

    // State, reference sample and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ACQUIRE;
            acq_cnt_r    <= {ACQ_W{1'b0}};
            good_cnt_r   <= {GOOD_W{1'b0}};
            bin_ref_r    <= {CBITS{1'b0}};
            bin_out_r    <= {CBITS{1'b0}};
            bin_valid_r  <= 1'b0;
            wrap_pulse_r <= 1'b0;
            step_err_r   <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            acq_cnt_r    <= acq_cnt_nxt_s;
            good_cnt_r   <= good_cnt_nxt_s;
            bin_ref_r    <= bin_ref_nxt_s;
            bin_out_r    <= bin_new_s;
            bin_valid_r  <= (state_nxt_s == TRACK);
            wrap_pulse_r <= wrap_nxt_s;
            step_err_r   <= step_err_nxt_s;
            if (step_err_nxt_s && (err_cnt_r != {ERR_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + ERR_W'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign bin_out    = bin_out_r;
    assign bin_valid  = bin_valid_r;
    assign wrap_pulse = wrap_pulse_r;
    assign step_err   = step_err_r;
    assign err_cnt    = err_cnt_r;
    assign lock_state = state_r;

`ifdef GRAY_RX_WRAP_CNT_EN
    logic [15:0] wrap_cnt_r;

    // Wrap counter advances on the same edge that raises wrap_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt_r <= 16'd0;
        end else if (wrap_nxt_s) begin
            wrap_cnt_r <= wrap_cnt_r + 16'd1;
        end else begin
            wrap_cnt_r <= wrap_cnt_r;
        end
    end

    assign wrap_cnt = wrap_cnt_r;
`else
    // No wrap counter in this build.
`endif

endmodule
